// File: rtl/counter_access_sequencer.sv
// counter_access_sequencer: bus-side control-word, count-write and latch/read-back sequencer for three 8254 counters
module counter_access_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS_n,
  input  logic        RD_n,
  input  logic        WR_n,
  input  logic [1:0]  A,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [15:0] OL_data0,
  input  logic [15:0] OL_data1,
  input  logic [15:0] OL_data2,
  input  logic [7:0]  status_in0,
  input  logic [7:0]  status_in1,
  input  logic [7:0]  status_in2,
  output logic [7:0]  control_word0,
  output logic [7:0]  control_word1,
  output logic [7:0]  control_word2,
  output logic [2:0]  cw_written,
  output logic [7:0]  count_data,
  output logic [2:0]  CRL_enable,
  output logic [2:0]  CRM_enable,
  output logic [2:0]  load_new_count,
  output logic [2:0]  OL_latch,
  output logic [2:0]  OL_release
);
  logic        prev_rd_n, prev_wr_n, rd_ev, wr_ev, rd, wr;
  logic [7:0]  cw [3];
  logic [7:0]  st [3];
  logic [7:0]  st_in [3];
  logic [15:0] ol [3];
  logic [2:0]  wtog, rtog, cl, sl;
  logic [1:0]  sc, rw;
  always_comb begin
    ol = '{OL_data0, OL_data1, OL_data2};
    st_in = '{status_in0, status_in1, status_in2};
    rd_ev = !CS_n && !RD_n && prev_rd_n;
    wr_ev = !CS_n && !WR_n && prev_wr_n;
    rd = rd_ev && !wr_ev;
    wr = wr_ev && !rd_ev;
    sc = D_in[7:6];
    rw = (A == 2'd3) ? 2'd0 : cw[A][5:4];
  end
  assign control_word0 = cw[0];
  assign control_word1 = cw[1];
  assign control_word2 = cw[2];
  always_ff @(posedge CLK) begin
    cw_written <= '0;
    CRL_enable <= '0;
    CRM_enable <= '0;
    load_new_count <= '0;
    OL_latch <= '0;
    OL_release <= '0;
    if (RESET) begin
      prev_rd_n <= 1'b1;
      prev_wr_n <= 1'b1;
      wtog <= '0;
      rtog <= '0;
      cl <= '0;
      sl <= '0;
      D_out <= 8'hFF;
      D_oe <= 1'b0;
      count_data <= '0;
      for (int i = 0; i < 3; i++) begin
        cw[i] <= '0;
        st[i] <= '0;
      end
    end else begin
      prev_rd_n <= RD_n;
      prev_wr_n <= WR_n;
      D_oe <= !CS_n && !RD_n && A != 2'd3;
      if (wr && A == 2'd3) begin
        if (sc != 2'd3) begin
          if (D_in[5:4] != 2'd0) begin
            cw[sc] <= D_in;
            cw_written[sc] <= 1'b1;
            wtog[sc] <= 1'b0;
            rtog[sc] <= 1'b0;
            cl[sc] <= 1'b0;
            sl[sc] <= 1'b0;
          end else if (!cl[sc]) begin
            OL_latch[sc] <= 1'b1;
            cl[sc] <= 1'b1;
          end
        end else begin
          for (int i = 0; i < 3; i++) begin
            if (D_in[1+i] && !D_in[5] && !cl[i]) begin
              OL_latch[i] <= 1'b1;
              cl[i] <= 1'b1;
            end
            if (D_in[1+i] && !D_in[4] && !sl[i]) begin
              st[i] <= st_in[i];
              sl[i] <= 1'b1;
            end
          end
        end
      end else if (wr && rw != 2'd0) begin
        count_data <= D_in;
        CRL_enable[A] <= rw == 2'd1 || (rw == 2'd3 && !wtog[A]);
        CRM_enable[A] <= rw == 2'd2 || (rw == 2'd3 && wtog[A]);
        load_new_count[A] <= rw != 2'd3 || wtog[A];
        if (rw == 2'd3) wtog[A] <= !wtog[A];
      end
      // Read completion is the final byte of the programmed access width
      if (rd && A == 2'd3) D_out <= 8'hFF;
      else if (rd && sl[A]) begin
        D_out <= st[A];
        sl[A] <= 1'b0;
      end else if (rd) begin
        D_out <= (rw == 2'd0) ? 8'hFF :
                 (rw == 2'd2 || (rw == 2'd3 && rtog[A])) ? ol[A][15:8] : ol[A][7:0];
        if (rw == 2'd3) rtog[A] <= !rtog[A];
        if (rw != 2'd0 && (rw != 2'd3 || rtog[A]) && cl[A]) begin
          OL_release[A] <= 1'b1;
          cl[A] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_counter_access_sequencer.sv
// tb_counter_access_sequencer: directed checks of control/count writes, latching, read-back and reset
module tb_counter_access_sequencer;
  logic        CLK = 0, RESET = 1, CS_n = 1, RD_n = 1, WR_n = 1;
  logic [1:0]  A = 0;
  logic [7:0]  D_in = 0, D_out;
  logic        D_oe;
  logic [15:0] OL_data0 = 16'h0102, OL_data1 = 16'h5566, OL_data2 = 16'h1234;
  logic [7:0]  status_in0 = 8'h96, status_in1 = 8'h11, status_in2 = 8'h22;
  logic [7:0]  control_word0, control_word1, control_word2, count_data;
  logic [2:0]  cw_written, CRL_enable, CRM_enable, load_new_count, OL_latch, OL_release;
  logic [2:0]  c_cw, c_crl, c_crm, c_lnc, c_oll, c_rel;
  logic [7:0]  c_cd, c_dout, d_prev;
  logic        c_doe;
  int          n_cmp = 0, n_err = 0;

  counter_access_sequencer dut (
    .CLK(CLK), .RESET(RESET), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A(A),
    .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
    .OL_data0(OL_data0), .OL_data1(OL_data1), .OL_data2(OL_data2),
    .status_in0(status_in0), .status_in1(status_in1), .status_in2(status_in2),
    .control_word0(control_word0), .control_word1(control_word1), .control_word2(control_word2),
    .cw_written(cw_written), .count_data(count_data), .CRL_enable(CRL_enable),
    .CRM_enable(CRM_enable), .load_new_count(load_new_count),
    .OL_latch(OL_latch), .OL_release(OL_release)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    c_cw = cw_written; c_crl = CRL_enable; c_crm = CRM_enable; c_lnc = load_new_count;
    c_oll = OL_latch; c_rel = OL_release; c_cd = count_data; c_dout = D_out; c_doe = D_oe;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge CLK); A = a; D_in = d; CS_n = 0; WR_n = 0;
    @(posedge CLK); #1; snap();
    @(negedge CLK); WR_n = 1; CS_n = 1;
  endtask

  task automatic rd(input logic [1:0] a);
    @(negedge CLK); A = a; CS_n = 0; RD_n = 0;
    @(posedge CLK); #1; snap();
    @(negedge CLK); RD_n = 1; CS_n = 1;
  endtask

  task automatic do_reset();
    @(negedge CLK); RESET = 1;
    repeat (2) @(negedge CLK);
    RESET = 0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RESET = 0;
    @(negedge CLK);
    chk("rst_dout", D_out, 8'hFF);
    chk("rst_doe", D_oe, 0);
    chk("rst_cw0", control_word0, 8'h00);
    wr(3, 8'h34);
    chk("cw0_val", control_word0, 8'h34);
    chk("cw0_pulse", c_cw, 3'b001);
    wr(0, 8'hAB);
    chk("lsb_crl", c_crl, 3'b001);
    chk("lsb_crm", c_crm, 3'b000);
    chk("lsb_lnc", c_lnc, 3'b000);
    chk("lsb_data", c_cd, 8'hAB);
    wr(0, 8'hCD);
    chk("msb_crl", c_crl, 3'b000);
    chk("msb_crm", c_crm, 3'b001);
    chk("msb_lnc", c_lnc, 3'b001);
    chk("msb_data", c_cd, 8'hCD);
    @(posedge CLK); #1;
    chk("pulse_one_cycle", {CRM_enable, load_new_count}, 6'b0);
    wr(3, 8'h50);
    chk("cw1_val", control_word1, 8'h50);
    wr(1, 8'h07);
    chk("rw01_crl", c_crl, 3'b010);
    chk("rw01_lnc", c_lnc, 3'b010);
    chk("rw01_crm", c_crm, 3'b000);
    wr(3, 8'hB0);
    chk("cw2_val", control_word2, 8'hB0);
    wr(3, 8'h80);
    chk("latch2_first", c_oll, 3'b100);
    wr(3, 8'h80);
    chk("latch2_second", c_oll, 3'b000);
    rd(2);
    chk("rd2_lsb", c_dout, 8'h34);
    chk("rd2_lsb_rel", c_rel, 3'b000);
    chk("rd2_doe", c_doe, 1);
    rd(2);
    chk("rd2_msb", c_dout, 8'h12);
    chk("rd2_msb_rel", c_rel, 3'b100);
    wr(3, 8'hE2);
    chk("rb_e2_cw0_kept", control_word0, 8'h34);
    rd(0);
    chk("rb_status", c_dout, 8'h96);
    rd(0);
    chk("rb_lsb", c_dout, 8'h02);
    rd(0);
    chk("rb_msb", c_dout, 8'h01);
    wr(3, 8'hC2);
    chk("rb_c2_latch", c_oll, 3'b001);
    status_in0 = 8'h3C;
    rd(0);
    chk("rb_c2_status", c_dout, 8'h96);
    rd(0);
    chk("rb_c2_lsb_rel", c_rel, 3'b000);
    rd(0);
    chk("rb_c2_msb_rel", c_rel, 3'b001);
    rd(3);
    chk("rd_ctrl_dout", c_dout, 8'hFF);
    chk("rd_ctrl_doe", c_doe, 0);
    wr(0, 8'h11);
    chk("pre_rst_crl", c_crl, 3'b001);
    do_reset();
    chk("mid_rst_cw0", control_word0, 8'h00);
    chk("mid_rst_dout", D_out, 8'hFF);
    wr(0, 8'h22);
    chk("unprog_pulses", {c_crl, c_crm, c_lnc}, 9'b0);
    wr(3, 8'h34);
    wr(0, 8'h55);
    chk("reprog_crl", c_crl, 3'b001);
    chk("reprog_crm", c_crm, 3'b000);
    rd(0);
    chk("pre_both_dout", c_dout, 8'h02);
    d_prev = D_out;
    @(negedge CLK); A = 0; D_in = 8'h77; CS_n = 0; RD_n = 0; WR_n = 0;
    @(posedge CLK); #1; snap();
    @(negedge CLK); CS_n = 1; RD_n = 1; WR_n = 1;
    chk("both_pulses", {c_cw, c_crl, c_crm, c_lnc, c_oll, c_rel}, 18'b0);
    chk("both_dout", c_dout, d_prev);
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
